// File: rtl/interface_pkg.sv
// rtl/interface_pkg.sv - shared memory request/response types and arbiter definitions
// Purpose: Memory_Request / Memory_Response bus structs shared by the caches,
//          the memory and mem_arbiter, plus the arbiter's state type and
//          request-count limit.
package interface_pkg;

  localparam int MEM_ADDR_W      = 32;
  localparam int MEM_DATA_W      = 32;
  localparam int MEM_ARB_MAX_REQ = 4;

  typedef struct packed {
    logic                  valid;
    logic                  rw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } Memory_Request;

  typedef struct packed {
    logic                  ready;
    logic [MEM_DATA_W-1:0] data;
  } Memory_Response;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache/memory side bundle of the memory arbiter
// Purpose: groups the per-cache request/response ports and the single memory
//          port seen by mem_arbiter.
// Signals:
//   ReqIn[NUM_REQ]   per-cache request into the arbiter
//   RespOut[NUM_REQ] per-cache response out of the arbiter
//   MemoryRequest    latched request toward Memory
//   MemoryResponse   response from Memory
//   grant_idx        current owner (meaningful only while busy)
//   busy             one transaction outstanding
// Modports: slave = arbiter side, master = caches/memory/bench side.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import interface_pkg::*;

  localparam int GRANT_W = $clog2(NUM_REQ);

  Memory_Request        ReqIn   [NUM_REQ];
  Memory_Response       RespOut [NUM_REQ];
  Memory_Request        MemoryRequest;
  Memory_Response       MemoryResponse;
  logic [GRANT_W-1:0]   grant_idx;
  logic                 busy;

  modport slave (
    input  ReqIn,
    input  MemoryResponse,
    output RespOut,
    output MemoryRequest,
    output grant_idx,
    output busy
  );

  modport master (
    output ReqIn,
    output MemoryResponse,
    input  RespOut,
    input  MemoryRequest,
    input  grant_idx,
    input  busy
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority selector
// Purpose: returns the first set bit of req_vec searching rr_ptr, rr_ptr+1, ...
//          modulo NUM_REQ.
// Ports:
//   req_vec   in  [NUM_REQ]  request bits
//   rr_ptr    in  GRANT_W    highest-priority index
//   any_valid out 1          at least one request set
//   pick_idx  out GRANT_W    selected index (0 when none)
module rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               any_valid,
  output logic [GRANT_W-1:0] pick_idx
);

  int                 idx;
  logic [GRANT_W-1:0] sel;

  // Walk from the farthest offset down to rr_ptr so the nearest hit wins.
  always_comb begin
    any_valid = 1'b0;
    pick_idx  = '0;
    idx       = 0;
    sel       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = GRANT_W'(idx);
      if (req_vec[sel]) begin
        any_valid = 1'b1;
        pick_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one Memory among NUM_REQ caches
// Purpose: grants one cache at a time, latches its request toward Memory and
//          routes Memory's response back to the owner only.
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   bus             mem_arbiter_if.slave (ReqIn, RespOut, MemoryRequest,
//                   MemoryResponse, grant_idx, busy)
//   perf_grant_cnt  out  [NUM_REQ] x 32 grants per cache   (MEM_ARB_PERF_EN)
//   perf_wait_cnt   out  [NUM_REQ] x 32 wait cycles per cache (MEM_ARB_PERF_EN)
// Optional feature macro: MEM_ARB_PERF_EN
module mem_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_grant_cnt [NUM_REQ],
  output logic [31:0]         perf_wait_cnt  [NUM_REQ]
`endif
);
  import interface_pkg::*;

  localparam int GRANT_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MEM_ARB_MAX_REQ) begin : g_bad_num_req
    $error("mem_arbiter: NUM_REQ out of range");
  end

  arb_state_e         r_state;
  logic [GRANT_W-1:0] r_rr_ptr;
  logic [GRANT_W-1:0] r_grant_idx;
  logic               r_busy;
  Memory_Request      r_mem_req;

  logic [NUM_REQ-1:0] w_req_vec;
  logic               w_any_valid;
  logic [GRANT_W-1:0] w_pick_idx;
  logic               w_done;

  always_comb begin
    w_req_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) w_req_vec[i] = bus.ReqIn[i].valid;
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
    .req_vec   (w_req_vec),
    .rr_ptr    (r_rr_ptr),
    .any_valid (w_any_valid),
    .pick_idx  (w_pick_idx)
  );

  assign w_done = (r_state == ARB_BUSY) && bus.MemoryResponse.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_busy      <= 1'b0;
      r_mem_req   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_valid) begin
            // Snapshot the winner; later changes on its ReqIn are not seen.
            r_mem_req       <= bus.ReqIn[w_pick_idx];
            r_mem_req.valid <= 1'b1;
            r_grant_idx     <= w_pick_idx;
            r_busy          <= 1'b1;
            r_state         <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus.MemoryResponse.ready) begin
            r_mem_req.valid <= 1'b0;
            r_busy          <= 1'b0;
            // Just-served index drops to lowest priority.
            r_rr_ptr        <= (r_grant_idx == GRANT_W'(NUM_REQ - 1)) ? '0
                                                                      : r_grant_idx + GRANT_W'(1);
            r_state         <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.MemoryRequest = r_mem_req;
  assign bus.grant_idx     = r_grant_idx;
  assign bus.busy          = r_busy;

  // Response passes straight through to the owner in the cycle Memory is ready;
  // gated by state so a stray ready after reset or while idle is dropped.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.RespOut[i] = '0;
      if (w_done && (r_grant_idx == GRANT_W'(i))) bus.RespOut[i] = bus.MemoryResponse;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0]        r_grant_cnt [NUM_REQ];
  logic [31:0]        r_wait_cnt  [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant_now;
  logic [NUM_REQ-1:0] w_owner;

  always_comb begin
    w_grant_now = '0;
    w_owner     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_grant_now[i] = (r_state == ARB_IDLE) && w_any_valid && (w_pick_idx == GRANT_W'(i));
      w_owner[i]     = (r_state == ARB_BUSY) && (r_grant_idx == GRANT_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= '0;
        r_wait_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant_now[i] && (r_grant_cnt[i] != '1))
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        // Waiting = asking but neither winning now nor already the owner.
        if (w_req_vec[i] && !w_grant_now[i] && !w_owner[i] && (r_wait_cnt[i] != '1))
          r_wait_cnt[i] <= r_wait_cnt[i] + 32'd1;
      end
    end
  end

  assign perf_grant_cnt = r_grant_cnt;
  assign perf_wait_cnt  = r_wait_cnt;
`endif

endmodule
